// File: rtl/sr_fetch.sv
// -----------------------------------------------------------------------------
// sr_fetch
//
// Instruction fetch stage. It sits directly upstream of a combinational
// instruction ROM, owns the program counter, and buffers fetched {pc, instr}
// pairs in a small FIFO toward decode. A redirect from execute flushes the
// buffer and restarts fetch at a new PC.
//
// Parameters
//   RESET_PC  byte address fetched first after reset (bits [1:0] ignored)
//   DEPTH     FIFO entries; power of 2, at least 2
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   imem_addr       ROM word index = fetch_pc >> 2 (registered, no input path)
//   imem_rd         ROM data for imem_addr, same cycle
//   redirect_valid  restart fetch at redirect_pc, flushing the buffer
//   redirect_pc     redirect byte address (bits [1:0] forced to 0)
//   out_valid       FIFO head is valid
//   out_ready       decode accepts the head this cycle
//   out_instr       instruction word at the FIFO head
//   out_pc          byte address of out_instr
// -----------------------------------------------------------------------------
module sr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  // Pointer width covers DEPTH entries exactly so pointers wrap for free;
  // the count needs one extra bit to represent "full".
  localparam int            PW               = $clog2(DEPTH);
  localparam int            CW               = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT       = CW'(DEPTH);
  localparam logic [31:0]   RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0]   fetch_pc;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          push;
  logic          pop;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  // NOTE: combinational logic uses blocking '=' so each line sees the value
  // computed just above it; registers below use '<=' so every flop samples
  // the pre-edge values regardless of statement order.
  always_comb begin
    // NOTE: every signal gets a value before any conditional logic, so no
    // path can leave it unassigned and infer a latch.
    pop  = 1'b0;
    push = 1'b0;

    pop  = out_valid & out_ready;
    // A full FIFO still accepts a new word when the head leaves in the same
    // cycle, which keeps the stream at one instruction per clock.
    push = ~redirect_valid & ((count < FULL_COUNT) | pop);
  end

  // The ROM address depends only on the PC register, never on an input, so
  // the ROM read path starts at a flop.
  assign imem_addr = {2'b00, fetch_pc[31:2]};

  // No bypass: the head always comes from storage, giving one cycle of
  // latency from fetch to visibility.
  assign out_valid = (count != '0);
  assign out_instr = instr_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];

  // ---------------------------------------------------------------------------
  // PC, pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC_ALIGNED;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      // A head popped this cycle is already owned by decode; everything
      // else is discarded simply by emptying the FIFO.
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        // Wraps modulo 2^32, so 32'hFFFF_FFFC is followed by 0.
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage is cleared on reset so out_pc/out_instr read as zero
  // immediately afterwards; this makes the array flops rather than a RAM
  // macro, which is the intended implementation for a buffer this small.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= imem_rd;
    end
  end

endmodule
